// File: rtl/seq_demux_4b_1to8_buf_if.sv
// rtl/seq_demux_4b_1to8_buf_if.sv - val/rdy bundle for the 4-bit 1-to-8 buffered demux router
interface seq_demux_4b_1to8_buf_if;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_;
    logic [2:0] sel;
    logic [7:0] out_val;
    logic [7:0] out_rdy;
    logic [3:0] out0;
    logic [3:0] out1;
    logic [3:0] out2;
    logic [3:0] out3;
    logic [3:0] out4;
    logic [3:0] out5;
    logic [3:0] out6;
    logic [3:0] out7;

    // Producer and lane consumers: drives the message, select and lane readies
    modport master (
        output in_val, in_, sel, out_rdy,
        input  in_rdy, out_val, out0, out1, out2, out3, out4, out5, out6, out7
    );

    // Router side
    modport slave (
        input  in_val, in_, sel, out_rdy,
        output in_rdy, out_val, out0, out1, out2, out3, out4, out5, out6, out7
    );
endinterface

// File: rtl/seq_demux_4b_1to8_buf.sv
// rtl/seq_demux_4b_1to8_buf.sv - registered 4-bit 1-to-8 demux with one-entry lane buffers; optional DEMUX_STATS_EN
module seq_demux_4b_1to8_buf (
    input  logic                   clk,
    input  logic                   reset,
    seq_demux_4b_1to8_buf_if.slave bus
`ifdef DEMUX_STATS_EN
    ,
    output logic [7:0]             xfer_count
`endif
);

    logic [7:0] full;
    logic [3:0] lane_buf [8];
    logic       in_xfer;
    logic [7:0] in_hit;
    logic [7:0] out_xfer;

    // Ready looks only at the selected lane; a full lane frees up when its consumer drains this edge
    always_comb begin
        bus.in_rdy = reset & (~full[bus.sel] | bus.out_rdy[bus.sel]);
        in_xfer    = bus.in_val & bus.in_rdy;
        in_hit     = in_xfer ? (8'b1 << bus.sel) : 8'h00;
        out_xfer   = full & bus.out_rdy;
    end

    // Per-lane buffer: a write wins over a drain so pass-through keeps the lane full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 8'h00;
            for (int k = 0; k < 8; k++) begin
                lane_buf[k] <= 4'h0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (in_hit[k]) begin
                    full[k]     <= 1'b1;
                    lane_buf[k] <= bus.in_;
                end else if (out_xfer[k]) begin
                    full[k]     <= 1'b0;
                end
            end
        end
    end

    // Lane outputs are masked to zero whenever the lane is empty
    always_comb begin
        bus.out_val = full;
        bus.out0    = full[0] ? lane_buf[0] : 4'h0;
        bus.out1    = full[1] ? lane_buf[1] : 4'h0;
        bus.out2    = full[2] ? lane_buf[2] : 4'h0;
        bus.out3    = full[3] ? lane_buf[3] : 4'h0;
        bus.out4    = full[4] ? lane_buf[4] : 4'h0;
        bus.out5    = full[5] ? lane_buf[5] : 4'h0;
        bus.out6    = full[6] ? lane_buf[6] : 4'h0;
        bus.out7    = full[7] ? lane_buf[7] : 4'h0;
    end

`ifdef DEMUX_STATS_EN
    // Accepted-message counter, wraps modulo 256
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_count <= 8'h00;
        end else if (in_xfer) begin
            xfer_count <= xfer_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_demux_4b_1to8_buf.sv
// tb/tb_seq_demux_4b_1to8_buf.sv - scoreboard bench for seq_demux_4b_1to8_buf
module tb_seq_demux_4b_1to8_buf;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [3:0] exp_q [8][$];
`ifdef DEMUX_STATS_EN
    logic [7:0] xfer_count;
`endif

    seq_demux_4b_1to8_buf_if bus ();

    seq_demux_4b_1to8_buf dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave)
`ifdef DEMUX_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] get_out(input int k);
        case (k)
            0: return bus.out0;
            1: return bus.out1;
            2: return bus.out2;
            3: return bus.out3;
            4: return bus.out4;
            5: return bus.out5;
            6: return bus.out6;
            default: return bus.out7;
        endcase
    endfunction

    task automatic clear_queues();
        for (int k = 0; k < 8; k++) exp_q[k].delete();
    endtask

    // Starts at posedge+1; offers one message and ends at the next posedge+1
    task automatic send(input logic [2:0] s, input logic [3:0] d, input logic exp_rdy);
        bus.in_val = 1'b1;
        bus.sel    = s;
        bus.in_    = d;
        #2;
        check("in_rdy", int'(bus.in_rdy), int'(exp_rdy));
        if (exp_rdy) exp_q[s].push_back(d);
        @(posedge clk);
        #1;
        bus.in_val = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2;
        reset = 1'b0;
        clear_queues();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every lane presenting data must match the head of its queue; a drain pops it
    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                if (bus.out_val[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("lane_unexpected", k, 99);
                    end else begin
                        check("lane_data", int'(get_out(k)), int'(exp_q[k][0]));
                        if (bus.out_rdy[k]) void'(exp_q[k].pop_front());
                    end
                end else begin
                    check("lane_idle_zero", int'(get_out(k)), 0);
                end
            end
        end
    end

    initial begin
        int total;
        checks = 0;
        errors = 0;
        reset       = 1'b0;
        bus.in_val  = 1'b1;
        bus.in_     = 4'h0;
        bus.sel     = 3'd0;
        bus.out_rdy = 8'h00;
        cyc();
        cyc();
        check("rst_out_val", int'(bus.out_val), 0);
        check("rst_in_rdy", int'(bus.in_rdy), 0);
        for (int k = 0; k < 8; k++) check("rst_out_k", int'(get_out(k)), 0);
`ifdef DEMUX_STATS_EN
        check("rst_xfer_count", int'(xfer_count), 0);
`endif
        bus.in_val = 1'b0;
        reset = 1'b1;
        cyc();

        // reset mid-operation with lanes 0 and 7 full
        send(3'd0, 4'h6, 1'b1);
        send(3'd7, 4'h9, 1'b1);
        check("fill_out_val", int'(bus.out_val), 8'h81);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_val", int'(bus.out_val), 0);
        for (int k = 0; k < 8; k++) check("midrst_out_k", int'(get_out(k)), 0);
        bus.in_val = 1'b1;
        bus.sel    = 3'd3;
        #1;
        check("midrst_in_rdy", int'(bus.in_rdy), 0);
`ifdef DEMUX_STATS_EN
        check("midrst_xfer_count", int'(xfer_count), 0);
`endif
        clear_queues();
        bus.in_val = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();

        // basic steer, then lane 2 full and stalled refuses a second message
        send(3'd2, 4'hA, 1'b1);
        check("steer_out_val", int'(bus.out_val), 8'h04);
        check("steer_out2", int'(bus.out2), 4'hA);
        send(3'd2, 4'hB, 1'b0);
        check("stall_out2", int'(bus.out2), 4'hA);

        // independence: lane 6 accepts while lane 2 stalls
        send(3'd6, 4'h5, 1'b1);
        check("indep_out_val", int'(bus.out_val), 8'h44);
        check("indep_out6", int'(bus.out6), 4'h5);
        check("indep_out2", int'(bus.out2), 4'hA);

        // pass-through on lane 1
        send(3'd1, 4'h3, 1'b1);
        bus.out_rdy = 8'h02;
        send(3'd1, 4'hC, 1'b1);
        bus.out_rdy = 8'h00;
        check("pass_out_val", int'(bus.out_val), 8'h46);
        check("pass_out1", int'(bus.out1), 4'hC);

        // drain to empty on lane 4
        send(3'd4, 4'hF, 1'b1);
        bus.out_rdy = 8'h10;
        cyc();
        bus.out_rdy = 8'h00;
        check("drain_out_val", int'(bus.out_val), 8'h46);
        check("drain_out4", int'(bus.out4), 0);

        // ready depends on sel and lane state, not on in_val
        bus.in_val = 1'b0;
        bus.sel    = 3'd2;
        #1;
        check("rdy_sel2_stalled", int'(bus.in_rdy), 0);
        bus.sel = 3'd5;
        #1;
        check("rdy_sel5_empty", int'(bus.in_rdy), 1);
        bus.sel = 3'd3;
        bus.in_ = 4'h7;
        cyc();
        cyc();
        check("dontcare_out_val", int'(bus.out_val), 8'h46);
`ifdef DEMUX_STATS_EN
        check("xfer_count_5", int'(xfer_count), 5);
`endif

        // drain everything; scoreboard must be empty afterwards
        bus.out_rdy = 8'hFF;
        cyc();
        cyc();
        bus.out_rdy = 8'h00;
        total = 0;
        for (int k = 0; k < 8; k++) total += exp_q[k].size();
        check("final_out_val", int'(bus.out_val), 0);
        check("final_queue_left", total, 0);

`ifdef DEMUX_STATS_EN
        pulse_reset();
        bus.out_rdy = 8'hFF;
        for (int i = 0; i < 257; i++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b1);
        end
        check("stats_257", int'(xfer_count), 8'h01);
        cyc();
        bus.out_rdy = 8'h00;
        cyc();
        send(3'd0, 4'h1, 1'b1);
        send(3'd0, 4'h2, 1'b0);
        check("stats_no_incr", int'(xfer_count), 8'h02);
        bus.out_rdy = 8'hFF;
        cyc();
        cyc();
        total = 0;
        for (int k = 0; k < 8; k++) total += exp_q[k].size();
        check("stats_queue_left", total, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
